// File: rtl/conv1d_pkg.sv
// Shared types and sizing helpers for the sequential 1-D convolution block.
package conv1d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAC    = 3'd1,
        ST_BIAS   = 3'd2,
        ST_NARROW = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    localparam int unsigned FRAC_DEFAULT = 12;

    // Accumulator wide enough for K*C full-precision products plus bias without wrap.
    function automatic int unsigned acc_width(input int unsigned w,
                                              input int unsigned k,
                                              input int unsigned c);
        return 2 * w + int'($clog2(k * c)) + 1;
    endfunction

    // Tap counter width; at least one bit so K=1 still has a counter.
    function automatic int unsigned tap_width(input int unsigned k);
        return (k > 1) ? int'($clog2(k)) : 1;
    endfunction

endpackage

// File: rtl/vec_mat_mac.sv
// One tap of the convolution: C-input by C-output multiply-sum against the
// weight ROM slice selected by the tap index. Purely combinational.
module vec_mat_mac
    import conv1d_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned C     = 4,
    parameter int unsigned K     = 4,
    parameter int unsigned ACC_W = 37,
    parameter int unsigned TAP_W = 2,
    parameter logic [K*C*C*W-1:0] WEIGHT_INIT = '0
) (
    input  logic [TAP_W-1:0]     tap,
    input  logic [K*C*W-1:0]     x_all,
    output logic [C*ACC_W-1:0]   y_c
);

    logic signed [W-1:0]     rom [K][C][C];
    logic signed [W-1:0]     xa  [K][C];
    logic signed [ACC_W-1:0] sum_c [C];

    // Unpack weight ROM (tap-major, then input channel, then output channel) and activations.
    for (genvar gk = 0; gk < K; gk++) begin : g_tap
        for (genvar gi = 0; gi < C; gi++) begin : g_in
            assign xa[gk][gi] = x_all[(gk*C+gi)*W +: W];
            for (genvar gj = 0; gj < C; gj++) begin : g_out
                assign rom[gk][gi][gj] = WEIGHT_INIT[((gk*C+gi)*C+gj)*W +: W];
            end
        end
    end

    // Full-precision signed product, sign-extended to 2W before multiplying.
    function automatic logic signed [2*W-1:0] smul(input logic signed [W-1:0] x_in,
                                                   input logic signed [W-1:0] w_in);
        return (2*W)'(x_in) * (2*W)'(w_in);
    endfunction

    // All C*C products of the selected tap summed per output channel.
    always_comb begin
        for (int j = 0; j < C; j++) begin
            sum_c[j] = '0;
            for (int i = 0; i < C; i++) begin
                sum_c[j] = sum_c[j] + ACC_W'(smul(xa[tap][i], rom[tap][i][j]));
            end
        end
    end

    // Flatten per-channel sums onto the output bus.
    always_comb begin
        y_c = '0;
        for (int j = 0; j < C; j++) begin
            y_c[j*ACC_W +: ACC_W] = sum_c[j];
        end
    end

endmodule

// File: rtl/conv1d_seq.sv
// Sequential 1-D convolution: captures K taps of C channels, accumulates one
// tap per cycle, adds bias, narrows to W bits with saturation and optional
// ReLU, then holds the result until the consumer accepts it.
// WEIGHT_INIT / BIAS_INIT carry the flattened contents of B_VALUES/weights.hex
// and B_VALUES/bias.hex (entry 0 in the least significant slot).
module conv1d_seq
    import conv1d_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned C    = 4,
    parameter int unsigned K    = 4,
    parameter int unsigned FRAC = FRAC_DEFAULT,
    parameter B_VALUES          = "qconv0_weights",
    parameter logic [K*C*C*W-1:0] WEIGHT_INIT = '0,
    parameter logic [C*2*W-1:0]   BIAS_INIT   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_v,
    output logic               in_ready,
    input  logic [K*C*W-1:0]   a,
    input  logic               apply_relu,
    output logic [C*W-1:0]     out,
    output logic               out_v,
    input  logic               out_ready
);

    localparam int unsigned ACC_W = acc_width(W, K, C);
    localparam int unsigned TAP_W = tap_width(K);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};

    // Elaboration-time parameter sanity.
    if (K < 1) begin : g_bad_k
        $error("conv1d_seq: K must be at least 1");
    end
    if ($bits(B_VALUES) == 0) begin : g_bad_dir
        $error("conv1d_seq: B_VALUES must name the weight directory");
    end

    state_e                  state_q, state_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_v_q, out_v_d;
    logic [K*C*W-1:0]        a_q, a_d;
    logic                    relu_q, relu_d;
    logic signed [ACC_W-1:0] acc_q [C];
    logic signed [ACC_W-1:0] acc_d [C];
    logic [C*W-1:0]          out_q, out_d;

    logic signed [2*W-1:0]   bias [C];
    logic [C*ACC_W-1:0]      mac_c;

    // Bias ROM, one 2W-bit entry per output channel.
    for (genvar gj = 0; gj < C; gj++) begin : g_bias
        assign bias[gj] = BIAS_INIT[gj*2*W +: 2*W];
    end

    vec_mat_mac #(
        .W           (W),
        .C           (C),
        .K           (K),
        .ACC_W       (ACC_W),
        .TAP_W       (TAP_W),
        .WEIGHT_INIT (WEIGHT_INIT)
    ) u_mac (
        .tap   (tap_q),
        .x_all (a_q),
        .y_c   (mac_c)
    );

    // Scale down by FRAC, saturate to W bits, then optionally clamp negatives.
    function automatic logic [W-1:0] narrow(input logic signed [ACC_W-1:0] v,
                                            input logic relu);
        logic signed [ACC_W-1:0] s;
        logic [W-1:0]            r;
        s = v >>> FRAC;
        if (s > SAT_MAX) begin
            r = OUT_MAX;
        end else if (s < SAT_MIN) begin
            r = OUT_MIN;
        end else begin
            r = W'(s);
        end
        if (relu && r[W-1]) begin
            r = '0;
        end
        return r;
    endfunction

    // Next-state and datapath updates for the capture/MAC/bias/narrow/hold sequence.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        out_v_d = out_v_q;
        a_d     = a_q;
        relu_d  = relu_q;
        acc_d   = acc_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE: begin
                if (in_v && in_ready_q) begin
                    a_d     = a;
                    relu_d  = apply_relu;
                    tap_d   = '0;
                    for (int j = 0; j < C; j++) begin
                        acc_d[j] = '0;
                    end
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                for (int j = 0; j < C; j++) begin
                    acc_d[j] = acc_q[j] + $signed(mac_c[j*ACC_W +: ACC_W]);
                end
                if (tap_q == TAP_W'(K - 1)) begin
                    state_d = ST_BIAS;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            ST_BIAS: begin
                for (int j = 0; j < C; j++) begin
                    acc_d[j] = acc_q[j] + ACC_W'(bias[j]);
                end
                state_d = ST_NARROW;
            end
            ST_NARROW: begin
                for (int j = 0; j < C; j++) begin
                    out_d[j*W +: W] = narrow(acc_q[j], relu_q);
                end
                out_v_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_v_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // Control registers; reset returns to IDLE ready for a new capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tap_q      <= '0;
            in_ready_q <= 1'b1;
            out_v_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            in_ready_q <= in_ready_d;
            out_v_q    <= out_v_d;
        end
    end

    // Datapath registers; reset discards any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            relu_q <= 1'b0;
            out_q  <= '0;
            for (int j = 0; j < C; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            a_q    <= a_d;
            relu_q <= relu_d;
            out_q  <= out_d;
            for (int j = 0; j < C; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign in_ready = in_ready_q;
    assign out_v    = out_v_q;
    assign out      = out_q;

endmodule

// File: tb/tb_conv1d_seq.sv
// Directed bench for conv1d_seq (K=4, C=4, W=16, FRAC=12) with four weight sets:
//   0: tap0 identity, bias 0    1: all taps identity, bias 0
//   2: zero weights, bias0=0x800  3: zero weights, bias0=0x1800
module tb_conv1d_seq;

    function automatic logic [1023:0] ident_w(input int ntaps);
        logic [1023:0] r;
        r = '0;
        for (int k = 0; k < ntaps; k++) begin
            for (int i = 0; i < 4; i++) begin
                r[((k*4+i)*4+i)*16 +: 16] = 16'h1000;
            end
        end
        return r;
    endfunction

    localparam logic [1023:0] W_TAP0 = ident_w(1);
    localparam logic [1023:0] W_ALL  = ident_w(4);
    localparam logic [127:0]  B_800  = {96'h0, 32'h0000_0800};
    localparam logic [127:0]  B_1800 = {96'h0, 32'h0000_1800};

    localparam logic [255:0] A_T1 = {192'h0, 64'h0000_F000_2000_1000};
    localparam logic [255:0] A_T3 = {4{64'h0000_0000_0000_7FFF}};
    localparam logic [255:0] A_T4 = {4{64'h0000_0000_0000_8000}};
    localparam logic [255:0] A_T5 = {64'h0000_0000_0400_0000, 64'h0000_0000_0300_0000,
                                     64'h0000_0000_0200_0000, 64'hFF00_0000_0100_0000};

    logic         clk;
    logic         rst;
    logic         in_v;
    logic [255:0] a;
    logic         apply_relu;
    logic         out_ready;
    logic         in_ready_x [4];
    logic         out_v_x    [4];
    logic [63:0]  out_x      [4];

    int n_tests;
    int n_fail;

    conv1d_seq #(.W(16), .C(4), .K(4), .FRAC(12), .B_VALUES("qconv0_weights"),
                 .WEIGHT_INIT(W_TAP0), .BIAS_INIT(128'h0)) u_dut0 (
        .clk(clk), .rst(rst), .in_v(in_v), .in_ready(in_ready_x[0]), .a(a),
        .apply_relu(apply_relu), .out(out_x[0]), .out_v(out_v_x[0]), .out_ready(out_ready));

    conv1d_seq #(.W(16), .C(4), .K(4), .FRAC(12), .B_VALUES("qconv0_weights"),
                 .WEIGHT_INIT(W_ALL), .BIAS_INIT(128'h0)) u_dut1 (
        .clk(clk), .rst(rst), .in_v(in_v), .in_ready(in_ready_x[1]), .a(a),
        .apply_relu(apply_relu), .out(out_x[1]), .out_v(out_v_x[1]), .out_ready(out_ready));

    conv1d_seq #(.W(16), .C(4), .K(4), .FRAC(12), .B_VALUES("qconv0_weights"),
                 .WEIGHT_INIT(1024'h0), .BIAS_INIT(B_800)) u_dut2 (
        .clk(clk), .rst(rst), .in_v(in_v), .in_ready(in_ready_x[2]), .a(a),
        .apply_relu(apply_relu), .out(out_x[2]), .out_v(out_v_x[2]), .out_ready(out_ready));

    conv1d_seq #(.W(16), .C(4), .K(4), .FRAC(12), .B_VALUES("qconv0_weights"),
                 .WEIGHT_INIT(1024'h0), .BIAS_INIT(B_1800)) u_dut3 (
        .clk(clk), .rst(rst), .in_v(in_v), .in_ready(in_ready_x[3]), .a(a),
        .apply_relu(apply_relu), .out(out_x[3]), .out_v(out_v_x[3]), .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] rdy_all();
        return {in_ready_x[3], in_ready_x[2], in_ready_x[1], in_ready_x[0]};
    endfunction

    function automatic logic [3:0] ov_all();
        return {out_v_x[3], out_v_x[2], out_v_x[1], out_v_x[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: capture, wait for out_v, optional stall with ignored in_v, release.
    task automatic run_txn(input string tag, input logic [255:0] av, input logic relu,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3,
                           input int stall);
        int lat;
        check({tag, "_ready_pre"}, 64'(rdy_all()), 64'hF);
        a          = av;
        apply_relu = relu;
        in_v       = 1'b1;
        @(posedge clk); #1;
        in_v       = 1'b0;
        a          = '1;
        apply_relu = ~relu;
        check({tag, "_ready_busy"}, 64'(rdy_all()), 64'h0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_v_x[0] && lat < 20);
        check({tag, "_latency"}, 64'(lat), 64'd6);
        check({tag, "_outv"}, 64'(ov_all()), 64'hF);
        check({tag, "_out0"}, out_x[0], e0);
        check({tag, "_out1"}, out_x[1], e1);
        check({tag, "_out2"}, out_x[2], e2);
        check({tag, "_out3"}, out_x[3], e3);
        for (int s = 0; s < stall; s++) begin
            in_v = s[0];
            a    = A_T3;
            @(posedge clk); #1;
            check({tag, "_hold_out0"}, out_x[0], e0);
            check({tag, "_hold_out1"}, out_x[1], e1);
            check({tag, "_hold_outv"}, 64'(ov_all()), 64'hF);
            check({tag, "_hold_ready"}, 64'(rdy_all()), 64'h0);
        end
        in_v      = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_outv_clr"}, 64'(ov_all()), 64'h0);
        check({tag, "_ready_post"}, 64'(rdy_all()), 64'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_v       = 1'b0;
        a          = '0;
        apply_relu = 1'b0;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outv", 64'(ov_all()), 64'h0);
        check("rst_out0", out_x[0], 64'h0);
        check("rst_out3", out_x[3], 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 64'(rdy_all()), 64'hF);

        // out_ready high while idle must not produce anything.
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("early_ready_outv", 64'(ov_all()), 64'h0);

        run_txn("t1", A_T1, 1'b0, 64'h0000_F000_2000_1000, 64'h0000_F000_2000_1000,
                64'h0, 64'h1, 0);
        run_txn("t2_relu", A_T1, 1'b1, 64'h0000_0000_2000_1000, 64'h0000_0000_2000_1000,
                64'h0, 64'h1, 0);
        run_txn("t3_satpos", A_T3, 1'b0, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_7FFF,
                64'h0, 64'h1, 0);
        run_txn("t4_satneg", A_T4, 1'b0, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000,
                64'h0, 64'h1, 0);
        run_txn("t5_multitap", A_T5, 1'b0, 64'hFF00_0000_0100_0000, 64'hFF00_0000_0A00_0000,
                64'h0, 64'h1, 0);
        run_txn("t6_stall", A_T1, 1'b0, 64'h0000_F000_2000_1000, 64'h0000_F000_2000_1000,
                64'h0, 64'h1, 10);
        run_txn("t7_after_stall", A_T1, 1'b1, 64'h0000_0000_2000_1000, 64'h0000_0000_2000_1000,
                64'h0, 64'h1, 0);

        // Reset while tap 2 is being accumulated.
        a    = A_T3;
        in_v = 1'b1;
        @(posedge clk); #1;
        in_v = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outv", 64'(ov_all()), 64'h0);
        check("midrst_out0", out_x[0], 64'h0);
        check("midrst_out1", out_x[1], 64'h0);
        check("midrst_out3", out_x[3], 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_ready", 64'(rdy_all()), 64'hF);
        @(posedge clk); #1;
        check("midrst_idle_outv", 64'(ov_all()), 64'h0);
        run_txn("t8_after_rst", A_T1, 1'b0, 64'h0000_F000_2000_1000, 64'h0000_F000_2000_1000,
                64'h0, 64'h1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
